// File: rtl/eth_mac_stats_pkg.sv
// Shared constants and types for the multi-port MAC statistics block.
// Event indices match the bit order of the per-port status pulse vector.
package eth_mac_stats_pkg;

    localparam int unsigned NUM_EVT_IN = 9;
    localparam int unsigned NUM_EVT    = 10;
    localparam int unsigned EVT_SEL_W  = 4;
    localparam int unsigned MAX_PORTS  = 16;
    localparam int unsigned PORT_IDX_W = 4;

    localparam int unsigned EVT_TX_UNDERFLOW      = 0;
    localparam int unsigned EVT_TX_FIFO_OVERFLOW  = 1;
    localparam int unsigned EVT_TX_FIFO_BAD_FRAME = 2;
    localparam int unsigned EVT_TX_FIFO_GOOD      = 3;
    localparam int unsigned EVT_RX_BAD_FRAME      = 4;
    localparam int unsigned EVT_RX_BAD_FCS        = 5;
    localparam int unsigned EVT_RX_FIFO_OVERFLOW  = 6;
    localparam int unsigned EVT_RX_FIFO_BAD_FRAME = 7;
    localparam int unsigned EVT_RX_FIFO_GOOD      = 8;
    localparam int unsigned EVT_SPEED_CHANGE      = 9;

    // Normalised read address, wide enough for the largest port count
    typedef struct packed {
        logic [PORT_IDX_W-1:0] port;
        logic [EVT_SEL_W-1:0]  evt;
    } rd_req_t;

    // True when the address names an existing counter
    function automatic logic idx_valid(input rd_req_t req, input int unsigned ports);
        return (32'(req.port) < ports) &&
               (req.evt <= EVT_SEL_W'(EVT_SPEED_CHANGE));
    endfunction

endpackage : eth_mac_stats_pkg

// File: rtl/eth_mac_stats_counter.sv
// One event counter: clear-all beats clear beats increment.
// A clear coinciding with an event leaves the counter at 1 so the event is kept.
module eth_mac_stats_counter
    import eth_mac_stats_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 32,
    parameter bit          SATURATE    = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inc,
    input  logic                   clr,
    input  logic                   clr_all,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   at_max
);

    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_next;
    logic                   w_full;

    assign w_full = &r_count;

    always_comb begin
        w_next = r_count;
        if (clr_all) begin
            w_next = '0;
        end else if (clr) begin
            w_next = COUNT_WIDTH'(inc);
        end else if (inc) begin
            if (SATURATE && w_full) begin
                w_next = r_count;
            end else begin
                w_next = r_count + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign count  = r_count;
    assign at_max = w_full;

endmodule : eth_mac_stats_counter

// File: rtl/eth_mac_stats_multi.sv
// Per-port MAC/FIFO event statistics with a single-entry read response port.
// Holds PORTS x NUM_EVT counters, speed-change detection and sticky saturation flags.
module eth_mac_stats_multi
    import eth_mac_stats_pkg::*;
#(
    parameter int unsigned PORTS         = 4,
    parameter int unsigned COUNT_WIDTH   = 32,
    parameter bit          SATURATE      = 1'b1,
    parameter bit          CLEAR_ON_READ = 1'b1,
    parameter int unsigned PORT_SEL_W    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                        logic_clk,
    input  logic                        logic_rst_n,
    input  logic [PORTS*NUM_EVT_IN-1:0] evt_in,
    input  logic [PORTS*2-1:0]          speed_in,
    input  logic                        clear_all,
    input  logic                        rd_valid,
    output logic                        rd_ready,
    input  logic [PORT_SEL_W-1:0]       rd_port,
    input  logic [EVT_SEL_W-1:0]        rd_event,
    output logic                        rd_resp_valid,
    input  logic                        rd_resp_ready,
    output logic [COUNT_WIDTH-1:0]      rd_resp_data,
    output logic                        rd_resp_error,
    output logic [PORTS-1:0]            sat_flag,
    output logic [PORTS*2-1:0]          link_speed
);

    localparam int unsigned NCNT  = PORTS * NUM_EVT;
    localparam int unsigned SEL_W = $clog2(NCNT + 1);

    logic                   r_primed;
    logic [PORTS*2-1:0]     r_link_speed;
    logic [PORTS-1:0]       r_sat;
    logic                   r_resp_valid;
    logic [COUNT_WIDTH-1:0] r_resp_data;
    logic                   r_resp_error;

    logic [PORTS-1:0]       w_spd_chg;
    logic [PORTS-1:0]       w_port_max;
    logic [NCNT-1:0]        w_inc;
    logic [NCNT-1:0]        w_clr;
    logic [NCNT-1:0]        w_at_max;
    logic [COUNT_WIDTH-1:0] w_count [NCNT];
    logic [COUNT_WIDTH-1:0] w_rd_data;
    rd_req_t                w_req;
    logic                   w_idx_ok;
    logic                   w_accept;
    logic [SEL_W-1:0]       w_sel;

    // Single response register without skid: accept only when it frees up
    assign rd_ready = !r_resp_valid || rd_resp_ready;
    assign w_accept = rd_valid && rd_ready;

    assign w_req    = '{port: PORT_IDX_W'(rd_port), evt: rd_event};
    assign w_idx_ok = idx_valid(w_req, PORTS);
    assign w_sel    = SEL_W'(32'(w_req.port) * NUM_EVT + 32'(w_req.evt));

    // Event wiring: nine status pulses plus the detected speed change per port
    for (genvar gp = 0; gp < PORTS; gp++) begin : g_port
        assign w_spd_chg[gp] = r_primed &&
                               (speed_in[gp*2 +: 2] != r_link_speed[gp*2 +: 2]);
        for (genvar ge = 0; ge < NUM_EVT_IN; ge++) begin : g_evt
            assign w_inc[gp*NUM_EVT + ge] = evt_in[gp*NUM_EVT_IN + ge];
        end
        assign w_inc[gp*NUM_EVT + EVT_SPEED_CHANGE] = w_spd_chg[gp];
        assign w_port_max[gp] = |w_at_max[gp*NUM_EVT +: NUM_EVT];
    end

    for (genvar gi = 0; gi < NCNT; gi++) begin : g_cnt
        eth_mac_stats_counter #(
            .COUNT_WIDTH (COUNT_WIDTH),
            .SATURATE    (SATURATE)
        ) u_cnt (
            .clk     (logic_clk),
            .rst_n   (logic_rst_n),
            .inc     (w_inc[gi]),
            .clr     (w_clr[gi]),
            .clr_all (clear_all),
            .count   (w_count[gi]),
            .at_max  (w_at_max[gi])
        );
    end

    // Read mux and clear-on-read strobe; an invalid address selects nothing
    always_comb begin
        w_rd_data = '0;
        w_clr     = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (w_idx_ok && (w_sel == SEL_W'(i))) begin
                w_rd_data = w_count[i];
                w_clr[i]  = CLEAR_ON_READ && w_accept;
            end
        end
    end

    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            r_primed     <= 1'b0;
            r_link_speed <= '0;
            r_sat        <= '0;
        end else begin
            r_primed     <= 1'b1;
            r_link_speed <= speed_in;
            r_sat        <= clear_all ? '0 : (r_sat | w_port_max);
        end
    end

    // Response register: captures the pre-update counter value at acceptance
    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_error <= 1'b0;
        end else if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_rd_data;
            r_resp_error <= !w_idx_ok;
        end else if (r_resp_valid && rd_resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign rd_resp_valid = r_resp_valid;
    assign rd_resp_data  = r_resp_data;
    assign rd_resp_error = r_resp_error;
    assign sat_flag      = r_sat;
    assign link_speed    = r_link_speed;

endmodule : eth_mac_stats_multi

// File: doc/eth_mac_stats_multi.md
# eth_mac_stats_multi

Multi-port statistics block for the 1G MAC FIFO wrappers, in the `logic_clk` domain. It counts per-port MAC and FIFO status pulses, plus link-speed changes, in saturating or wrapping counters. Counters are read through a single valid/ready request/response port with optional clear-on-read. It sits beside up to `PORTS` MAC+FIFO instances whose status outputs are already synchronised into `logic_clk`.

## Interface
Parameters:
- `PORTS`, 4: number of MAC ports monitored; range 1..16.
- `COUNT_WIDTH`, 32: counter width; range 8..48.
- `SATURATE`, 1: 1 = counters stick at all-ones; 0 = counters wrap.
- `CLEAR_ON_READ`, 1: 1 = an accepted read zeroes the addressed counter.
- `PORT_SEL_W`, `PORTS>1 ? $clog2(PORTS) : 1`: width of `rd_port`.

Ports:
- `logic_clk`  in  1  sole clock.
- `logic_rst_n`  in  1  asynchronous, active-low reset.
- `evt_in`  in  `PORTS*9`  status pulses. Port p occupies `[p*9 +: 9]`. Bit order: 0 tx_error_underflow, 1 tx_fifo_overflow, 2 tx_fifo_bad_frame, 3 tx_fifo_good_frame, 4 rx_error_bad_frame, 5 rx_error_bad_fcs, 6 rx_fifo_overflow, 7 rx_fifo_bad_frame, 8 rx_fifo_good_frame.
- `speed_in`  in  `PORTS*2`  per-port MAC speed code, already synchronised.
- `clear_all`  in  1  single-cycle pulse; zeroes every counter and `sat_flag`.
- `rd_valid`  in  1  read request valid.
- `rd_ready`  out  1  read request ready.
- `rd_port`  in  `PORT_SEL_W`  port index for the read.
- `rd_event`  in  4  event index for the read: 0..8 as in `evt_in`, 9 = speed_change.
- `rd_resp_valid`  out  1  response valid.
- `rd_resp_ready`  in  1  response ready.
- `rd_resp_data`  out  `COUNT_WIDTH`  counter value.
- `rd_resp_error`  out  1  set when the requested index is invalid.
- `sat_flag`  out  `PORTS`  sticky flag: some counter of the port has reached all-ones.
- `link_speed`  out  `PORTS*2`  registered copy of `speed_in`.

## Operation
- Counter set: `PORTS`×10 counters. Events 0..8 come from `evt_in`; event 9 is speed_change.
- Each cycle with an event bit high adds +1 to its counter; a level held N cycles counts N.
- speed_change fires when `speed_in[p]` differs from `link_speed[p]`. The first cycle after reset release is excluded through a `primed` flag.
- Saturation (`SATURATE`=1): a counter at all-ones stays there. `sat_flag[p]` sets on any counter of port p reaching all-ones, in both modes, and is cleared only by `clear_all` or reset.
- Reads:
  - A request is accepted when `rd_valid && rd_ready`.
  - `rd_ready = !rd_resp_valid || rd_resp_ready`, giving a single response register with no skid.
  - The response holds `rd_resp_data`/`rd_resp_error` stable until `rd_resp_valid && rd_resp_ready`.
- Invalid index: `rd_port >= PORTS` or `rd_event > 9` → `rd_resp_error`=1, data 0, no counter is modified.
- Clear-on-read: the addressed counter becomes 0. If its event is high in the same cycle, it becomes 1 instead, so no event is lost.
- `clear_all` priority: `clear_all` > clear-on-read > increment. Events in the `clear_all` cycle are discarded. A read accepted in that cycle returns the pre-clear value.

## Timing
- Reset values: all counters 0, `sat_flag` 0, `link_speed` 0, `primed` 0, `rd_resp_valid` 0, `rd_resp_data` 0, `rd_resp_error` 0, `rd_ready` 1.
- Event latency: an event in cycle T is visible to a read accepted in cycle T+1 or later.
- Read accepted in cycle T:
  - The response counts events from cycles < T.
  - `rd_resp_valid` rises in T+1.
  - Back-to-back reads sustain one per cycle while `rd_resp_ready`=1.
- Wrap mode: all-ones +1 → 0.
- `link_speed` tracks `speed_in` with 1 cycle latency. speed_change increments in the cycle the mismatch is seen.
- Reset asserted mid-transaction: any response is dropped and state returns to the reset values immediately (asynchronous).

## Structure
- Shared package `eth_mac_stats_pkg`, holding:
  - event index constants `EVT_TX_UNDERFLOW`..`EVT_SPEED_CHANGE` (0..9);
  - `NUM_EVT_IN`=9, `NUM_EVT`=10, event select width 4.
- Sub-module `eth_mac_stats_counter`:
  - one counter with inc/clr/clr_all inputs, the `SATURATE` mode and an `at_max` output;
  - instantiated `PORTS`×10 times through a generate.
- Top level: speed-change detect, `primed` flag, read mux, response register, `sat_flag` OR-reduce.

## Test plan
- Reset release with `speed_in`=2'b10 on all ports → every counter reads 0 and speed_change=0 (primed guard); `link_speed`=2'b10.
- Port 2, 5 pulses of event 8, then read (2,8) → data 5, error 0. With `CLEAR_ON_READ`=1 an immediate re-read → 0.
- `COUNT_WIDTH`=8, `SATURATE`=1, event 0 held 300 cycles → read 255 and `sat_flag[p]`=1. Same with `SATURATE`=0 → read 44 and `sat_flag[p]`=1.
- Read of (1,3) accepted in the same cycle event 3 is high, prior count 7 → response 7; next read → 1.
- `rd_resp_ready`=0 for 4 cycles with `rd_valid` held → `rd_ready`=0 and response data stable; on release, both requests complete in order.
- Read with `rd_event`=12, or `rd_port`=`PORTS` → error 1, data 0. `clear_all` together with an accepted read of a counter holding 9 → response 9, all counters 0 afterwards.
